// File: rtl/risac_tcm.sv
// Single-ported word RAM serving the risac instruction and data buses.
// The dbus has priority; loads go through a small wait-state FSM, stores complete in one cycle.
module risac_tcm #(
    parameter int unsigned ADDR_W       = 10,
    parameter int unsigned DBUS_RD_WAIT = 0,
    parameter string       INIT_FILE    = ""
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] ibus_addr,
    input  logic        ibus_read,
    output logic [31:0] ibus_rdata,
    output logic [31:0] ibus_raddr,
    output logic        ibus_wait,
    input  logic [31:0] dbus_addr,
    input  logic        dbus_read,
    input  logic        dbus_we,
    input  logic [31:0] dbus_wdata,
    input  logic [3:0]  dbus_byteen,
    output logic [31:0] dbus_rdata,
    output logic        dbus_wait,
    output logic        dbus_misalign
);

    typedef enum logic [1:0] {StIdle, StRdWait, StRdDone} state_t;

    localparam logic [3:0] CntInit = (DBUS_RD_WAIT > 0) ? 4'(DBUS_RD_WAIT - 1) : 4'd0;

    logic [31:0] mem [2**ADDR_W];

    state_t            state;
    logic [3:0]        cnt;
    logic [31:0]       rd_word;
    logic [1:0]        rd_off;
    logic [31:0]       rdata_hold;

    logic [ADDR_W-1:0] iword;
    logic [ADDR_W-1:0] dword;
    logic [1:0]        doff;
    logic [7:0]        lanes;
    logic [31:0]       wdata_sh;
    logic [31:0]       rd_shift;
    logic              dbus_own;
    logic              dwrite;
    logic              dread;
    logic              ibus_fire;
    logic              unused_addr;

    assign iword    = ibus_addr[ADDR_W+1:2];
    assign dword    = dbus_addr[ADDR_W+1:2];
    assign doff     = dbus_addr[1:0];
    // Lanes [7:4] fall outside the addressed word and are only used to flag misalignment.
    assign lanes    = {4'b0000, dbus_byteen} << doff;
    assign wdata_sh = dbus_wdata << {doff, 3'b000};
    assign rd_shift = rd_word >> {rd_off, 3'b000};

    assign dbus_own  = (state == StIdle) && (dbus_read || dbus_we);
    assign dwrite    = (state == StIdle) && dbus_we;
    assign dread     = (state == StIdle) && dbus_read && !dbus_we;
    assign ibus_fire = ibus_read && !dbus_own;

    assign ibus_wait  = ibus_read && dbus_own;
    assign dbus_wait  = dread || (state == StRdWait);
    assign dbus_rdata = (state == StRdDone) ? rd_shift : rdata_hold;

    assign unused_addr = ^{ibus_addr[1:0], dbus_addr[31:ADDR_W+2]};

    always_ff @(posedge clk) begin
        if (dwrite && !rst) begin
            for (int i = 0; i < 4; i++) begin
                if (lanes[i]) mem[dword][8*i +: 8] <= wdata_sh[8*i +: 8];
            end
        end
        if (dread) rd_word <= mem[dword];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= StIdle;
            cnt           <= 4'd0;
            rd_off        <= 2'd0;
            rdata_hold    <= 32'd0;
            ibus_rdata    <= 32'd0;
            ibus_raddr    <= 32'd0;
            dbus_misalign <= 1'b0;
        end else begin
            if (ibus_fire) begin
                ibus_rdata <= mem[iword];
                ibus_raddr <= {ibus_addr[31:2], 2'b00};
            end
            if ((dbus_read || dbus_we) && (lanes[7:4] != 4'd0)) dbus_misalign <= 1'b1;
            unique case (state)
                StIdle: begin
                    if (dread) begin
                        rd_off <= doff;
                        cnt    <= CntInit;
                        state  <= (DBUS_RD_WAIT > 0) ? StRdWait : StRdDone;
                    end
                end
                StRdWait: begin
                    if (cnt == 4'd0) state <= StRdDone;
                    else             cnt   <= cnt - 4'd1;
                end
                StRdDone: begin
                    rdata_hold <= rd_shift;
                    state      <= StIdle;
                end
                default: state <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_risac_tcm.sv
// Randomised bench for risac_tcm against a cycle-level behavioural model of the bus protocol.
module tb_risac_tcm;

    localparam int unsigned RDW = 3;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] ibus_addr = '0;
    logic        ibus_read = 1'b0;
    logic [31:0] ibus_rdata;
    logic [31:0] ibus_raddr;
    logic        ibus_wait;
    logic [31:0] dbus_addr = '0;
    logic        dbus_read = 1'b0;
    logic        dbus_we = 1'b0;
    logic [31:0] dbus_wdata = '0;
    logic [3:0]  dbus_byteen = '0;
    logic [31:0] dbus_rdata;
    logic        dbus_wait;
    logic        dbus_misalign;

    risac_tcm #(
        .ADDR_W       (10),
        .DBUS_RD_WAIT (RDW),
        .INIT_FILE    ("")
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .ibus_addr     (ibus_addr),
        .ibus_read     (ibus_read),
        .ibus_rdata    (ibus_rdata),
        .ibus_raddr    (ibus_raddr),
        .ibus_wait     (ibus_wait),
        .dbus_addr     (dbus_addr),
        .dbus_read     (dbus_read),
        .dbus_we       (dbus_we),
        .dbus_wdata    (dbus_wdata),
        .dbus_byteen   (dbus_byteen),
        .dbus_rdata    (dbus_rdata),
        .dbus_wait     (dbus_wait),
        .dbus_misalign (dbus_misalign)
    );

    always #5 clk = ~clk;

    int n_pass  = 0;
    int n_total = 0;

    // Reference model state
    logic [31:0] mem_m [1024];
    logic [31:0] ir_m, ia_m, dr_m, ld_data;
    logic        mis_m;
    logic        ld_act;
    int          ld_left;
    logic [31:0] pc;
    logic        dwait_s;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    endtask

    // One bus cycle: drive, check combinational outputs, clock, update model, check registers.
    task automatic cycle(input logic ir, input logic rd, input logic we, input logic [31:0] da,
                         input logic [31:0] wd, input logic [3:0] be);
        logic        own, grant, done;
        logic [9:0]  w;
        logic [1:0]  off;
        logic [7:0]  ln;
        logic [31:0] exp_dr;
        @(negedge clk);
        ibus_read = ir; ibus_addr = pc;
        dbus_read = rd; dbus_we = we; dbus_addr = da; dbus_wdata = wd; dbus_byteen = be;
        w      = da[11:2];
        off    = da[1:0];
        ln     = {4'b0000, be};
        ln     = ln << off;
        own    = !ld_act && (rd || we);
        grant  = ir && !own;
        done   = ld_act && (ld_left == 0);
        exp_dr = done ? ld_data : dr_m;
        #1;
        dwait_s = dbus_wait;
        check("ibus_wait", 32'(ibus_wait), 32'(ir && own));
        check("dbus_wait", 32'(dbus_wait), 32'((!ld_act && rd && !we) || (ld_act && ld_left > 0)));
        check("dbus_rdata", dbus_rdata, exp_dr);
        @(posedge clk);
        #1;
        if (grant) begin
            ir_m = mem_m[pc[11:2]];
            ia_m = {pc[31:2], 2'b00};
            pc   = pc + 32'd4;
        end
        if (ld_act) begin
            if (ld_left > 0) ld_left--;
            else begin
                ld_act = 1'b0;
                dr_m   = ld_data;
            end
        end else if (we) begin
            for (int k = 0; k < 4; k++)
                if (ln[k]) mem_m[w][8*k +: 8] = wd[8*(k-off) +: 8];
        end else if (rd) begin
            ld_data = mem_m[w] >> (8 * off);
            ld_left = RDW;
            ld_act  = 1'b1;
        end
        if ((rd || we) && ln[7:4] != 4'd0) mis_m = 1'b1;
        check("ibus_rdata", ibus_rdata, ir_m);
        check("ibus_raddr", ibus_raddr, ia_m);
        check("dbus_misalign", 32'(dbus_misalign), 32'(mis_m));
    endtask

    task automatic do_reset(input logic rd, input logic [31:0] da);
        @(negedge clk);
        rst = 1'b1; ibus_read = 1'b1; dbus_read = rd; dbus_we = 1'b0; dbus_addr = da;
        dbus_byteen = 4'hF;
        @(posedge clk);
        #1;
        rst = 1'b0;
        ir_m = '0; ia_m = '0; dr_m = '0; mis_m = 1'b0; ld_act = 1'b0; ld_left = 0;
        check("rst_ibus_rdata", ibus_rdata, 32'd0);
        check("rst_ibus_raddr", ibus_raddr, 32'd0);
        check("rst_dbus_rdata", dbus_rdata, 32'd0);
        check("rst_misalign", 32'(dbus_misalign), 32'd0);
    endtask

    task automatic do_load(input logic [31:0] a, input logic [3:0] be);
        int waits = 0;
        int n = 0;
        cycle(1'b1, 1'b1, 1'b0, a, 32'd0, be);
        if (dwait_s) waits++;
        while (ld_act && n < 32) begin
            cycle(1'b1, 1'b1, 1'b0, a, 32'd0, be);
            if (dwait_s) waits++;
            n++;
        end
        check("load_wait_cycles", 32'(waits), 32'(RDW + 1));
    endtask

    initial begin
        logic        rd, we, ir;
        logic [31:0] da;
        logic [3:0]  be;
        int          r;
        pc = $urandom;
        ir_m = '0; ia_m = '0; dr_m = '0; ld_data = '0; mis_m = 1'b0; ld_act = 1'b0;
        ld_left = 0; dwait_s = 1'b0;
        do_reset(1'b0, 32'd0);
        do_reset(1'b0, 32'd0);

        // Fill every word so the model knows the whole RAM; ibus is stalled throughout.
        for (int i = 0; i < 1024; i++) cycle(1'b1, 1'b0, 1'b1, 32'(i * 4), $urandom, 4'hF);

        cycle(1'b1, 1'b0, 1'b1, 32'h10, 32'hDEADBEEF, 4'hF);
        do_load(32'h10, 4'hF);
        check("lw_deadbeef", dbus_rdata, 32'hDEADBEEF);

        cycle(1'b1, 1'b0, 1'b1, 32'h10, 32'h0, 4'hF);
        cycle(1'b1, 1'b0, 1'b1, 32'h13, 32'h000000AA, 4'b0001);
        cycle(1'b1, 1'b0, 1'b1, 32'h10, 32'h00001234, 4'b0011);
        do_load(32'h10, 4'hF);
        check("lw_bytes", dbus_rdata, 32'hAA001234);
        do_load(32'h13, 4'b0001);
        check("lb_top", dbus_rdata, 32'h000000AA);

        cycle(1'b1, 1'b0, 1'b1, 32'h0F, 32'h0000BBCC, 4'b0011);
        check("misalign_set", 32'(dbus_misalign), 32'd1);
        do_load(32'h0C, 4'hF);
        check("misalign_lane3", dbus_rdata >> 24, 32'h000000CC);
        do_load(32'h10, 4'hF);
        check("misalign_next_word", dbus_rdata, 32'hAA001234);
        check("misalign_sticky", 32'(dbus_misalign), 32'd1);

        cycle(1'b1, 1'b0, 1'b1, 32'h20, 32'h0BADF00D, 4'hF);
        cycle(1'b1, 1'b1, 1'b0, 32'h20, 32'd0, 4'hF);
        cycle(1'b1, 1'b1, 1'b0, 32'h20, 32'd0, 4'hF);
        do_reset(1'b1, 32'h20);
        do_load(32'h20, 4'hF);
        check("load_after_reset", dbus_rdata, 32'h0BADF00D);

        da = '0;
        be = 4'hF;
        for (int i = 0; i < 600; i++) begin
            ir = ($urandom_range(0, 3) != 0);
            if (ld_act) begin
                rd = 1'b1;
                we = 1'b0;
            end else begin
                r  = $urandom_range(0, 9);
                we = (r < 3) || (r == 9);
                rd = (r >= 3 && r < 6) || (r == 9);
                da = $urandom;
                r  = $urandom_range(0, 2);
                be = (r == 0) ? 4'b0001 : (r == 1) ? 4'b0011 : 4'b1111;
            end
            cycle(ir, rd, we, da, $urandom, be);
        end
        while (ld_act) cycle(1'b1, 1'b1, 1'b0, da, 32'd0, be);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
